filter_result_collector: RTL



---
 rtl/filter_pkg.sv | 12 +
 rtl/filter_idx_checker.sv | 42 ++++
 rtl/filter_result_collector.sv | 111 +++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Constants and types shared by the filter-select sequencer and the result collector.
package filter_pkg;

    localparam int NUM_FILTERS = 9;
    localparam int IDX_W       = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collect_state_t;

endpackage

// File: rtl/filter_idx_checker.sv
// Tracks the filter index the collector expects next and classifies each incoming tag.
module filter_idx_checker #(
    parameter int NUM_FILTERS = filter_pkg::NUM_FILTERS,
    parameter int IDX_W       = filter_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             accept,
    input  logic [IDX_W-1:0] idx,
    output logic             match,
    output logic             restart,
    output logic             error,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

    logic [IDX_W-1:0] expected;

    // An out-of-range tag can never equal expected, so it lands in the error path.
    assign match   = (idx == expected);
    assign error   = !match;
    assign restart = !match && (idx == '0);
    assign last    = match && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expected <= '0;
        end else if (accept) begin
            if (last) begin
                expected <= '0;
            end else if (match) begin
                expected <= expected + IDX_W'(1);
            end else if (restart) begin
                expected <= IDX_W'(1);
            end else begin
                expected <= '0;
            end
        end
    end

endmodule

// File: rtl/filter_result_collector.sv
// Packs one in-order beat per filter into a wide word and hands it downstream.
// Assembly buffer and output register are separate so the next group fills while one drains.
module filter_result_collector
    import filter_pkg::collect_state_t, filter_pkg::COLLECT, filter_pkg::HOLD;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_FILTERS = filter_pkg::NUM_FILTERS,
    parameter int IDX_W       = filter_pkg::IDX_W,
    parameter int GRP_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [IDX_W-1:0]              in_filter_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FILTERS*DATA_W-1:0] out_data,
    output logic                          seq_error,
    output logic [GRP_W-1:0]              group_count
);

    localparam int OUT_W = NUM_FILTERS * DATA_W;

    // Handshakes: a transfer happens on a rising edge where valid && ready; a source
    // holds valid and its payload stable until that edge, and ready never waits on valid.
    collect_state_t   state, state_next;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic             accept, out_fire;
    logic             match, restart, error, last;
    logic             load_collect, load_hold, load;

    assign in_ready = (state == COLLECT);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign load     = load_collect || load_hold;

    filter_idx_checker #(
        .NUM_FILTERS(NUM_FILTERS),
        .IDX_W      (IDX_W)
    ) u_idx_checker (
        .clk    (clk),
        .reset_n(reset_n),
        .accept (accept),
        .idx    (in_filter_idx),
        .match  (match),
        .restart(restart),
        .error  (error),
        .last   (last)
    );

    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if (accept && (match || restart) && (in_filter_idx == IDX_W'(k))) begin
                asm_d[k*DATA_W +: DATA_W] = in_data;
            end
        end
    end

    always_comb begin
        state_next   = state;
        load_collect = 1'b0;
        load_hold    = 1'b0;
        case (state)
            COLLECT: begin
                // Completing group may take the output slot if it is empty or draining now.
                if (accept && last) begin
                    if (!out_valid || out_ready) begin
                        load_collect = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    load_hold  = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= COLLECT;
            asm_q       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            seq_error   <= 1'b0;
            group_count <= '0;
        end else begin
            state     <= state_next;
            asm_q     <= asm_d;
            out_valid <= load || (out_valid && !out_fire);
            if (load) begin
                out_data <= asm_d;
            end
            if (accept && error) begin
                seq_error <= 1'b1;
            end
            if (out_fire) begin
                group_count <= group_count + GRP_W'(1);
            end
        end
    end

endmodule
